// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO read-side drain and write-side producer.
package fifo_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // Buffer slots committed once this cycle settles: held + arriving - leaving (2-bit wrap).
    function automatic logic [1:0] credit_use(input logic [1:0] occ,
                                              input logic       inflight,
                                              input logic       xfer);
        return occ + {1'b0, inflight} - {1'b0, xfer};
    endfunction

endpackage

// File: rtl/fifo_rd_drain_if.sv
// Valid/ready byte stream presented by the read-side drain to downstream logic.
interface fifo_rd_drain_if #(
    parameter int DATA_W = fifo_pkg::DATA_W
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fifo_rd_drain_chk.sv
// Invariants of the 2-entry skid buffer, bound in by the buffer itself.
module fifo_rd_drain_chk
    import fifo_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    input logic       in_valid,
    input logic [1:0] occ
);

    // The credit rule must never let a capture land on a full buffer.
    a_no_capture_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_valid && (occ == OCC_TWO)));

    a_occ_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (occ != 2'd3));

endmodule

// File: rtl/fifo_rd_drain_skid_buf2.sv
// Two-entry skid buffer absorbing the FIFO read latency; head is always the stream output.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occ
);

    logic [1:0]        occ_r;
    logic [1:0]        occ_s;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] head_s;
    logic [DATA_W-1:0] tail_r;
    logic [DATA_W-1:0] tail_s;
    logic              xfer_s;

    assign out_valid = (occ_r != OCC_EMPTY);
    assign out_data  = head_r;
    assign occ       = occ_r;
    assign xfer_s    = out_valid & out_ready;

    // Next buffer state from capture and transfer; head only moves when it is consumed or empty.
    always_comb begin
        occ_s  = occ_r;
        head_s = head_r;
        tail_s = tail_r;
        case (occ_r)
            OCC_EMPTY: begin
                if (in_valid) begin
                    occ_s  = OCC_ONE;
                    head_s = in_data;
                end else begin
                    occ_s = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                if (in_valid && !xfer_s) begin
                    occ_s  = OCC_TWO;
                    tail_s = in_data;
                end else if (in_valid && xfer_s) begin
                    head_s = in_data;
                end else if (xfer_s) begin
                    occ_s = OCC_EMPTY;
                end else begin
                    occ_s = OCC_ONE;
                end
            end
            OCC_TWO: begin
                if (xfer_s) begin
                    occ_s  = OCC_ONE;
                    head_s = tail_r;
                end else begin
                    occ_s = OCC_TWO;
                end
            end
            default: begin
                occ_s = OCC_EMPTY;
            end
        endcase
    end

    // Buffer state and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r  <= OCC_EMPTY;
            head_r <= {DATA_W{1'b0}};
            tail_r <= {DATA_W{1'b0}};
        end else begin
            occ_r  <= occ_s;
            head_r <= head_s;
            tail_r <= tail_s;
        end
    end

    fifo_rd_drain_chk u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .occ      (occ_r)
    );

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain: pops the FIFO under buffer credit and streams bytes out through a skid buffer.
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd,
    fifo_rd_drain_if.master   m,
    output logic [CNT_W-1:0]  pop_count,
    output logic              busy
);

    logic              inflight_r;
    logic [1:0]        occ_s;
    logic              valid_s;
    logic [DATA_W-1:0] data_s;
    logic              xfer_s;
    logic [1:0]        credit_s;
    logic              pop_s;
    logic [CNT_W-1:0]  pop_count_r;

    assign xfer_s   = valid_s & m.ready;
    assign credit_s = credit_use(occ_s, inflight_r, xfer_s);
    // Gated by rst_n so no pop (and no lost FIFO byte) occurs while held in reset.
    assign pop_s    = rst_n & en & ~fifo_empty & (credit_s < 2'd2);

    assign fifo_rd   = pop_s;
    assign m.valid   = valid_s;
    assign m.data    = data_s;
    assign pop_count = pop_count_r;
    assign busy      = inflight_r | valid_s;

    // Read-latency tracker and wrapping pop counter.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r  <= 1'b0;
            pop_count_r <= {CNT_W{1'b0}};
        end else begin
            inflight_r <= pop_s;
            if (pop_s) begin
                pop_count_r <= pop_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                pop_count_r <= pop_count_r;
            end
        end
    end

    skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (rd_clk),
        .rst_n     (rst_n),
        .in_valid  (inflight_r),
        .in_data   (fifo_rdata),
        .out_valid (valid_s),
        .out_data  (data_s),
        .out_ready (m.ready),
        .occ       (occ_s)
    );

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain against a small FIFO model; CNT_W=4 to reach the counter wrap.
module tb_fifo_rd_drain;
    import fifo_pkg::*;

    localparam int CNT_W = 4;

    logic             rd_clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata = 8'h00;
    logic             fifo_rd;
    logic             m_ready;
    logic [CNT_W-1:0] pop_count;
    logic             busy;

    logic [7:0] mem [0:31];
    logic [4:0] wr_ptr = 5'd0;
    logic [4:0] rd_ptr = 5'd0;

    int checks = 0;
    int errors = 0;
    int pops;
    int cyc;
    int first_rd, last_rd, first_v, last_v;
    logic [7:0] got [$];
    logic [7:0] expq [$];

    fifo_rd_drain_if #(.DATA_W(8)) m_if ();
    assign m_if.ready = m_ready;

    fifo_rd_drain #(.DATA_W(8), .CNT_W(CNT_W)) dut (
        .rd_clk     (rd_clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .m          (m_if),
        .pop_count  (pop_count),
        .busy       (busy)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: rdata valid the cycle after a pop.
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge rd_clk) begin
        if (fifo_rd) begin
            fifo_rdata <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 5'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 5'd1;
        expq.push_back(b);
    endtask

    task automatic clear();
        pops = 0; cyc = 0;
        first_rd = -1; last_rd = -1; first_v = -1; last_v = -1;
        got.delete();
    endtask

    task automatic reset_dut();
        en = 1'b0; m_ready = 1'b0; rst_n = 1'b0;
        @(posedge rd_clk); #1;
        rst_n = 1'b1;
    endtask

    // Advance n cycles, sampling pops and transfers on the falling edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge rd_clk);
            if (fifo_rd) begin
                pops++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (m_if.valid && m_ready) begin
                got.push_back(m_if.data);
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            cyc++;
            @(posedge rd_clk); #1;
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD, {24'h0, expq[i]});
        end
        got.delete();
        expq.delete();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
        clear();
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        check("rst_fifo_rd", fifo_rd, 1'b0);
        check("rst_m_valid", m_if.valid, 1'b0);
        check("rst_m_data", m_if.data, 8'h00);
        check("rst_pop_count", pop_count, 4'd0);
        check("rst_busy", busy, 1'b0);
        @(posedge rd_clk); #1;
        rst_n = 1'b1;

        // Single byte: pop at t, valid at t+2.
        push(8'hB1); en = 1'b1; m_ready = 1'b1;
        @(negedge rd_clk);
        check("single_rd_t0", fifo_rd, 1'b1);
        check("single_valid_t0", m_if.valid, 1'b0);
        @(posedge rd_clk); #1; @(negedge rd_clk);
        check("single_rd_t1", fifo_rd, 1'b0);
        check("single_busy_t1", busy, 1'b1);
        check("single_valid_t1", m_if.valid, 1'b0);
        @(posedge rd_clk); #1; @(negedge rd_clk);
        check("single_valid_t2", m_if.valid, 1'b1);
        check("single_data_t2", m_if.data, 8'hB1);
        @(posedge rd_clk); #1; @(negedge rd_clk);
        check("single_valid_t3", m_if.valid, 1'b0);
        check("single_busy_t3", busy, 1'b0);
        check("single_pop_count", pop_count, 4'd1);
        expq.delete();
        @(posedge rd_clk); #1;

        // Streaming: back-to-back pops and transfers.
        reset_dut(); clear();
        push(8'hB1); push(8'hFD); push(8'h3C); push(8'h5A);
        en = 1'b1; m_ready = 1'b1;
        run(10);
        check("stream_pops", pops, 4);
        check("stream_first_rd", first_rd, 0);
        check("stream_last_rd", last_rd, 3);
        check("stream_first_valid", first_v, 2);
        check("stream_last_valid", last_v, 5);
        check("stream_pop_count", pop_count, 4'd4);
        check_stream("stream_data");

        // Backpressure: two pops then stall with the first byte held.
        reset_dut(); clear();
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        en = 1'b1; m_ready = 1'b0;
        run(6);
        check("bp_pops", pops, 2);
        check("bp_fifo_rd", fifo_rd, 1'b0);
        check("bp_valid", m_if.valid, 1'b1);
        check("bp_hold_data", m_if.data, 8'h20);
        check("bp_pop_count", pop_count, 4'd2);
        check("bp_no_xfer", got.size(), 0);
        m_ready = 1'b1;
        run(16);
        check("bp_pop_count_end", pop_count, 4'd8);
        check_stream("bp_data");

        // Enable drop the cycle after a pop.
        reset_dut(); clear();
        push(8'hC0); push(8'hC1); push(8'hC2);
        en = 1'b1; m_ready = 1'b1;
        run(1);
        en = 1'b0;
        run(6);
        check("en_pops", pops, 1);
        check("en_inflight_delivered", got.size(), 1);
        check("en_busy_idle", busy, 1'b0);
        en = 1'b1;
        run(8);
        check("en_pop_count", pop_count, 4'd3);
        check_stream("en_data");

        // Empty FIFO: never pop.
        reset_dut(); clear();
        en = 1'b1; m_ready = 1'b1;
        run(5);
        check("empty_pops", pops, 0);
        check("empty_pop_count", pop_count, 4'd0);
        check("empty_busy", busy, 1'b0);

        // Asynchronous reset with two bytes buffered.
        reset_dut(); clear();
        push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
        en = 1'b1; m_ready = 1'b0;
        run(4);
        check("rmid_valid_before", m_if.valid, 1'b1);
        check("rmid_pop_count_before", pop_count, 4'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_valid", m_if.valid, 1'b0);
        check("rmid_data", m_if.data, 8'h00);
        check("rmid_busy", busy, 1'b0);
        check("rmid_pop_count", pop_count, 4'd0);
        check("rmid_fifo_rd", fifo_rd, 1'b0);
        @(posedge rd_clk); #1;
        rst_n = 1'b1;
        void'(expq.pop_front());
        void'(expq.pop_front());
        clear(); m_ready = 1'b1;
        run(8);
        check("rmid_pop_count_after", pop_count, 4'd2);
        check_stream("rmid_data_after");

        // Counter wrap: 17 pops on a 4-bit counter.
        reset_dut(); clear();
        for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
        en = 1'b1; m_ready = 1'b1;
        run(24);
        check("wrap_pops", pops, 17);
        check("wrap_pop_count", pop_count, 4'd1);
        check_stream("wrap_data");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
